// File: rtl/seg7_pkg.sv
// Shared seven-segment constants, scan FSM states and frame record for the display read-back path.
// Purely declarative; no logic, no latency, no flow control.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h18;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] BCD_BLANK_NIBBLE = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      HELD
   } scan_state_t;

   typedef struct packed {
      logic [15:0] bcd;
      logic [3:0]  blank;
   } frame_t;

   function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps an active-low segment pattern back to a BCD nibble, blank or invalid.
// Combinational, zero latency; no flow control.
// Blank and invalid patterns both report BCD_BLANK_NIBBLE on the nibble output.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       is_blank,
   output logic       is_invalid
);

   always_comb begin
      nibble     = BCD_BLANK_NIBBLE;
      is_blank   = 1'b0;
      is_invalid = 1'b0;
      case (pattern)
         SEG_0:     nibble = 4'd0;
         SEG_1:     nibble = 4'd1;
         SEG_2:     nibble = 4'd2;
         SEG_3:     nibble = 4'd3;
         SEG_4:     nibble = 4'd4;
         SEG_5:     nibble = 4'd5;
         SEG_6:     nibble = 4'd6;
         SEG_7:     nibble = 4'd7;
         SEG_8:     nibble = 4'd8;
         SEG_9:     nibble = 4'd9;
         SEG_BLANK: is_blank = 1'b1;
         default:   is_invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/hex_scan_reader.sv
// Recovers the BCD word from a multiplexed active-low 4-digit 7-seg bus; optional ERR_CNT via HEX_READER_ERRCNT_EN.
// Latency: VALID STABLE_CYCLES+1 edges after digit 3 is first sampled; ERR one edge after the offending registered sample.
// No backpressure: the display bus is free-running, frames are either published or dropped with an ERR pulse.
module hex_scan_reader
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic [6:0]  SEG_N,
   input  logic [3:0]  DIG_SEL,
   output logic [15:0] BCD_OUT,
   output logic [3:0]  BLANK,
   output logic        VALID,
   output logic        ERR
`ifdef HEX_READER_ERRCNT_EN
   ,
   output logic [7:0]  ERR_CNT
`endif
);

   localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

   logic [6:0]  seg_q;
   logic [6:0]  seg_prev;
   logic [3:0]  sel_q;

   scan_state_t state;
   logic [1:0]  idx;
   logic [7:0]  cnt;
   frame_t      shadow;

   logic [3:0]  dec_nibble;
   logic        dec_blank;
   logic        dec_invalid;

   logic        start_digit;
   logic        keep_digit;
   logic        capture;
   logic        fault;
   logic [1:0]  idx_tgt;
   logic [7:0]  cnt_nxt;
   frame_t      shadow_nxt;

   seg7_pattern_decode u_decode (
      .pattern    (seg_q),
      .nibble     (dec_nibble),
      .is_blank   (dec_blank),
      .is_invalid (dec_invalid)
   );

   // seg_prev trails seg_q by one cycle so COUNT can detect a pattern change
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         seg_q    <= SEG_BLANK;
         seg_prev <= SEG_BLANK;
         sel_q    <= 4'b0000;
      end else begin
         seg_q    <= SEG_N;
         seg_prev <= seg_q;
         sel_q    <= DIG_SEL;
      end
   end

   always_comb begin
      start_digit = 1'b0;
      keep_digit  = 1'b0;
      capture     = 1'b0;
      fault       = 1'b0;
      idx_tgt     = idx;
      cnt_nxt     = 8'd1;
      shadow_nxt  = shadow;

      case (state)
         IDLE: begin
            if (sel_q == 4'b0001) begin
               start_digit = 1'b1;
               idx_tgt     = 2'd0;
            end
         end
         COUNT: begin
            if (sel_q == digit_onehot(idx)) begin
               keep_digit = 1'b1;
               if (seg_q == seg_prev)
                  cnt_nxt = (cnt >= STABLE_CNT) ? STABLE_CNT : cnt + 8'd1;
            end else begin
               fault = 1'b1;
            end
         end
         HELD: begin
            if (sel_q == digit_onehot(idx + 2'd1)) begin
               start_digit = 1'b1;
               idx_tgt     = idx + 2'd1;
            end else if (sel_q != digit_onehot(idx) && sel_q != 4'b0000) begin
               fault = 1'b1;
            end
         end
         default: ;
      endcase

      // Entering a digit counts as the first stable sample, so STABLE_CYCLES=1 captures on entry
      if ((start_digit || keep_digit) && cnt_nxt >= STABLE_CNT) begin
         capture = 1'b1;
         if (dec_invalid)
            fault = 1'b1;
      end

      shadow_nxt.bcd[{idx_tgt, 2'b00} +: 4] = dec_nibble;
      shadow_nxt.blank[idx_tgt]             = dec_blank;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= IDLE;
         idx     <= 2'd0;
         cnt     <= 8'd0;
         shadow  <= '0;
         BCD_OUT <= 16'h0000;
         BLANK   <= 4'b0000;
         VALID   <= 1'b0;
         ERR     <= 1'b0;
      end else begin
         VALID <= 1'b0;
         ERR   <= 1'b0;
         if (fault) begin
            ERR    <= 1'b1;
            state  <= IDLE;
            idx    <= 2'd0;
            cnt    <= 8'd0;
            shadow <= '0;
         end else if (capture && idx_tgt == 2'd3) begin
            BCD_OUT <= shadow_nxt.bcd;
            BLANK   <= shadow_nxt.blank;
            VALID   <= 1'b1;
            state   <= IDLE;
            idx     <= 2'd0;
            cnt     <= 8'd0;
            shadow  <= '0;
         end else if (capture) begin
            shadow <= shadow_nxt;
            idx    <= idx_tgt;
            cnt    <= cnt_nxt;
            state  <= HELD;
         end else if (start_digit || keep_digit) begin
            state <= COUNT;
            idx   <= idx_tgt;
            cnt   <= cnt_nxt;
         end
      end
   end

`ifdef HEX_READER_ERRCNT_EN
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N)
         ERR_CNT <= 8'h00;
      else if (ERR && ERR_CNT != 8'hFF)
         ERR_CNT <= ERR_CNT + 8'd1;
   end
`endif

endmodule

// File: tb/tb_hex_scan_reader.sv
// Bench for hex_scan_reader: drives scanned display frames, scoreboards published words.
module tb_hex_scan_reader;

   localparam int S = 4;

   typedef struct packed {
      logic [15:0] bcd;
      logic [3:0]  blank;
   } exp_t;

   logic        clk = 1'b0;
   logic        RESET_N;
   logic [6:0]  SEG_N;
   logic [3:0]  DIG_SEL;
   logic [15:0] BCD_OUT;
   logic [3:0]  BLANK;
   logic        VALID;
   logic        ERR;
`ifdef HEX_READER_ERRCNT_EN
   logic [7:0]  ERR_CNT;
`endif

   int checks = 0;
   int errors = 0;
   int valid_seen = 0;
   int err_seen = 0;
   int cyc = 0;
   int valid_cyc = 0;
   exp_t sb_q[$];

   hex_scan_reader #(.STABLE_CYCLES(S)) dut (
      .CLOCK_50 (clk),
      .RESET_N  (RESET_N),
      .SEG_N    (SEG_N),
      .DIG_SEL  (DIG_SEL),
      .BCD_OUT  (BCD_OUT),
      .BLANK    (BLANK),
      .VALID    (VALID),
      .ERR      (ERR)
`ifdef HEX_READER_ERRCNT_EN
      ,
      .ERR_CNT  (ERR_CNT)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every VALID pops one expected frame
   always @(negedge clk) begin
      if (RESET_N) begin
         if (VALID || ERR) begin
            checks++;
            if (VALID && ERR) begin
               errors++;
               $display("FAIL valid_err_overlap: VALID=%b ERR=%b, required not both high", VALID, ERR);
            end
         end
         if (ERR) err_seen++;
         if (VALID) begin
            exp_t e;
            valid_seen++;
            valid_cyc = cyc;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: BCD_OUT=%h with no frame expected", BCD_OUT);
            end else begin
               e = sb_q.pop_front();
               if (BCD_OUT !== e.bcd) begin
                  errors++;
                  $display("FAIL sb_bcd: got %h, expected %h", BCD_OUT, e.bcd);
               end
               checks++;
               if (BLANK !== e.blank) begin
                  errors++;
                  $display("FAIL sb_blank: got %b, expected %b", BLANK, e.blank);
               end
            end
         end
      end
   end

   function automatic logic [6:0] pat_of(input int v);
      case (v)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h18;
         default: return 7'h7F;
      endcase
   endfunction

   // digit value 15 stands for a blank digit
   function automatic exp_t mk_exp(input int d0, input int d1, input int d2, input int d3);
      exp_t e;
      int d[4];
      d = '{d0, d1, d2, d3};
      for (int i = 0; i < 4; i++) begin
         e.bcd[i*4 +: 4] = (d[i] == 15) ? 4'hF : 4'(d[i]);
         e.blank[i]      = (d[i] == 15);
      end
      return e;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_sel(input logic [3:0] sel, input logic [6:0] pat, input int n);
      DIG_SEL = sel;
      SEG_N   = pat;
      tick(n);
   endtask

   task automatic drive(input int d, input logic [6:0] pat, input int n);
      logic [3:0] sel;
      sel = 4'b0001 << d;
      drive_sel(sel, pat, n);
   endtask

   task automatic gap(input int n);
      drive_sel(4'b0000, 7'h7F, n);
   endtask

   task automatic send_frame(input int d0, input int d1, input int d2, input int d3,
                             input int dwell, input int gp);
      int d[4];
      d = '{d0, d1, d2, d3};
      for (int i = 0; i < 4; i++) begin
         drive(i, pat_of(d[i]), dwell);
         gap(gp);
      end
   endtask

   task automatic test_reset;
      RESET_N = 1'b0;
      SEG_N   = 7'h7F;
      DIG_SEL = 4'b0000;
      tick(3);
      checks++; if (BCD_OUT !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h, expected 0000", BCD_OUT); end
      checks++; if (BLANK !== 4'b0000) begin errors++; $display("FAIL reset_blank: got %b, expected 0000", BLANK); end
      checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", VALID); end
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, expected 0", ERR); end
`ifdef HEX_READER_ERRCNT_EN
      checks++; if (ERR_CNT !== 8'h00) begin errors++; $display("FAIL reset_errcnt: got %h, expected 00", ERR_CNT); end
`endif
      RESET_N = 1'b1;
      tick(2);
   endtask

   task automatic test_clean;
      int v0, e0, start;
      v0 = valid_seen; e0 = err_seen;
      sb_q.push_back(mk_exp(3, 0, 2, 1));
      drive(0, pat_of(3), 6); gap(2);
      drive(1, pat_of(0), 6); gap(2);
      drive(2, pat_of(2), 6); gap(2);
      start = cyc;
      drive(3, pat_of(1), 6); gap(2);
      tick(3);
      checks++; if (valid_seen - v0 != 1) begin errors++; $display("FAIL clean_valid_count: got %0d, expected 1", valid_seen - v0); end
      checks++; if (err_seen != e0) begin errors++; $display("FAIL clean_err_count: got %0d, expected 0", err_seen - e0); end
      checks++; if (BCD_OUT !== 16'h1203) begin errors++; $display("FAIL clean_bcd: got %h, expected 1203", BCD_OUT); end
      checks++; if (BLANK !== 4'b0000) begin errors++; $display("FAIL clean_blank: got %b, expected 0000", BLANK); end
      checks++; if (valid_cyc - start != S + 1) begin errors++; $display("FAIL clean_latency: got %0d edges, expected %0d", valid_cyc - start, S + 1); end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL clean_pending: %0d frames never published", sb_q.size()); sb_q.delete(); end
   endtask

   task automatic test_blank;
      int v0;
      v0 = valid_seen;
      sb_q.push_back(mk_exp(0, 9, 15, 15));
      send_frame(0, 9, 15, 15, 6, 2);
      tick(3);
      checks++; if (valid_seen - v0 != 1) begin errors++; $display("FAIL blank_valid_count: got %0d, expected 1", valid_seen - v0); end
      checks++; if (BCD_OUT !== 16'hFF90) begin errors++; $display("FAIL blank_bcd: got %h, expected FF90", BCD_OUT); end
      checks++; if (BLANK !== 4'b1100) begin errors++; $display("FAIL blank_flags: got %b, expected 1100", BLANK); end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL blank_pending: %0d frames never published", sb_q.size()); sb_q.delete(); end
   endtask

   task automatic test_back_to_back;
      int v0, e0;
      v0 = valid_seen; e0 = err_seen;
      sb_q.push_back(mk_exp(1, 2, 3, 4));
      sb_q.push_back(mk_exp(5, 6, 7, 8));
      send_frame(1, 2, 3, 4, S + 1, 0);
      send_frame(5, 6, 7, 8, S + 1, 0);
      gap(4);
      checks++; if (valid_seen - v0 != 2) begin errors++; $display("FAIL b2b_valid_count: got %0d, expected 2", valid_seen - v0); end
      checks++; if (err_seen != e0) begin errors++; $display("FAIL b2b_err_count: got %0d, expected 0", err_seen - e0); end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_pending: %0d frames never published", sb_q.size()); sb_q.delete(); end
   endtask

   task automatic test_glitch;
      int v0, e0;
      v0 = valid_seen; e0 = err_seen;
      sb_q.push_back(mk_exp(5, 1, 7, 4));
      drive(0, pat_of(5), 6); gap(2);
      drive(1, 7'h79, 2); drive(1, 7'h00, 1); drive(1, 7'h79, 5); gap(2);
      drive(2, pat_of(7), 6); gap(2);
      drive(3, pat_of(4), 6); gap(4);
      checks++; if (valid_seen - v0 != 1) begin errors++; $display("FAIL glitch_long_valid: got %0d, expected 1", valid_seen - v0); end
      checks++; if (BCD_OUT !== 16'h4715) begin errors++; $display("FAIL glitch_long_bcd: got %h, expected 4715", BCD_OUT); end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL glitch_pending: %0d frames never published", sb_q.size()); sb_q.delete(); end
      v0 = valid_seen; e0 = err_seen;
      drive(0, pat_of(5), 6); gap(2);
      drive(1, 7'h79, 2); drive(1, 7'h00, 1); drive(1, 7'h79, 2); gap(4);
      checks++; if (err_seen - e0 != 1) begin errors++; $display("FAIL glitch_short_err: got %0d, expected 1", err_seen - e0); end
      checks++; if (valid_seen != v0) begin errors++; $display("FAIL glitch_short_valid: got %0d, expected 0", valid_seen - v0); end
      checks++; if (BCD_OUT !== 16'h4715) begin errors++; $display("FAIL glitch_short_bcd: got %h, expected 4715", BCD_OUT); end
   endtask

   task automatic test_invalid;
      int v0, e0;
      v0 = valid_seen; e0 = err_seen;
      drive(0, pat_of(2), 6); gap(2);
      drive(1, pat_of(3), 6); gap(2);
      drive(2, 7'h55, 8); gap(2);
      drive(3, pat_of(9), 6); gap(4);
      checks++; if (err_seen - e0 != 1) begin errors++; $display("FAIL invalid_err: got %0d, expected 1", err_seen - e0); end
      checks++; if (valid_seen != v0) begin errors++; $display("FAIL invalid_valid: got %0d, expected 0", valid_seen - v0); end
      checks++; if (BCD_OUT !== 16'h4715) begin errors++; $display("FAIL invalid_bcd: got %h, expected 4715", BCD_OUT); end
      checks++; if (BLANK !== 4'b0000) begin errors++; $display("FAIL invalid_blank: got %b, expected 0000", BLANK); end
   endtask

   task automatic test_order;
      int e0;
      e0 = err_seen;
      drive(0, pat_of(1), 6);
      drive_sel(4'b0100, pat_of(2), 3); gap(3);
      checks++; if (err_seen - e0 != 1) begin errors++; $display("FAIL order_skip_err: got %0d, expected 1", err_seen - e0); end
      e0 = err_seen;
      drive(0, pat_of(1), 2);
      drive_sel(4'b0011, pat_of(1), 2); gap(3);
      checks++; if (err_seen - e0 != 1) begin errors++; $display("FAIL order_multihot_err: got %0d, expected 1", err_seen - e0); end
      checks++; if (BCD_OUT !== 16'h4715) begin errors++; $display("FAIL order_bcd: got %h, expected 4715", BCD_OUT); end
   endtask

   task automatic test_reset_mid;
      int v0, e0;
      v0 = valid_seen; e0 = err_seen;
      drive(0, pat_of(1), 6); gap(1);
      drive(1, pat_of(2), 6); gap(1);
      drive(2, pat_of(3), 6);
      RESET_N = 1'b0;
      #1;
      checks++; if (BCD_OUT !== 16'h0000) begin errors++; $display("FAIL midreset_bcd: got %h, expected 0000", BCD_OUT); end
      checks++; if (BLANK !== 4'b0000) begin errors++; $display("FAIL midreset_blank: got %b, expected 0000", BLANK); end
      drive(3, pat_of(4), 3);
      RESET_N = 1'b1;
      drive(3, pat_of(4), 4); gap(3);
      checks++; if (valid_seen != v0) begin errors++; $display("FAIL midreset_valid: got %0d, expected 0", valid_seen - v0); end
      checks++; if (err_seen != e0) begin errors++; $display("FAIL midreset_err: got %0d, expected 0", err_seen - e0); end
      sb_q.push_back(mk_exp(9, 8, 7, 6));
      send_frame(9, 8, 7, 6, 6, 2);
      tick(3);
      checks++; if (valid_seen - v0 != 1) begin errors++; $display("FAIL fresh_valid: got %0d, expected 1", valid_seen - v0); end
      checks++; if (BCD_OUT !== 16'h6789) begin errors++; $display("FAIL fresh_bcd: got %h, expected 6789", BCD_OUT); end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL fresh_pending: %0d frames never published", sb_q.size()); sb_q.delete(); end
   endtask

   task automatic test_err_count;
      int e0;
      e0 = err_seen;
      for (int i = 0; i < 300; i++) begin
         drive(0, pat_of(0), 1);
         gap(2);
      end
      gap(3);
      checks++; if (err_seen - e0 != 300) begin errors++; $display("FAIL errburst_count: got %0d, expected 300", err_seen - e0); end
`ifdef HEX_READER_ERRCNT_EN
      checks++; if (ERR_CNT !== 8'hFF) begin errors++; $display("FAIL errcnt_sat: got %h, expected FF", ERR_CNT); end
`endif
      checks++; if (BCD_OUT !== 16'h6789) begin errors++; $display("FAIL errburst_bcd: got %h, expected 6789", BCD_OUT); end
   endtask

   initial begin
      test_reset;
      test_clean;
      test_blank;
      test_back_to_back;
      test_glitch;
      test_invalid;
      test_order;
      test_reset_mid;
      test_err_count;
      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
